// File: rtl/tc_capture_pkg.sv
// Shared widths and capture FSM encoding for the counter-capture slice.
package tc_capture_pkg;

  localparam int unsigned Q_W        = 4;
  localparam int unsigned DEF_WRAP_W = 8;
  localparam int unsigned SNAP_W     = DEF_WRAP_W + Q_W;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector: registers the input and pulses for the one cycle it goes 0 -> 1.
module rise_det (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic PULSE
);

  logic d_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_q <= 1'b0;
    end else begin
      d_q <= D;
    end
  end

  // Level held high yields a single pulse; a high level right after reset still counts.
  assign PULSE = D & ~d_q;

endmodule

// File: rtl/tc_capture.sv
// Counts wraps of an upstream 4-bit counter and captures {wraps, Q} into a one-deep hand-off slot.
module tc_capture
  import tc_capture_pkg::*;
#(
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Q_W-1:0]        Q,
  input  logic                  RCO,
  input  logic                  CNT_CLR,
  input  logic                  CAP,
  input  logic                  RDY,
  input  logic                  CLR_OVF,
  output logic [WRAP_W+Q_W-1:0] SNAP,
  output logic                  VALID,
  output logic                  OVF,
  output logic [WRAP_W-1:0]     WRAPS
);

  logic                  wrap_evt;
  logic [WRAP_W-1:0]     wraps_q, wraps_d;
  logic [WRAP_W+Q_W-1:0] snap_q, snap_d;
  cap_state_e            state_q, state_d;
  logic                  ovf_q, ovf_d;
  logic                  drop;

  rise_det u_rco_rise (
    .CLK   (CLK),
    .RST   (RST),
    .D     (RCO),
    .PULSE (wrap_evt)
  );

  always_comb begin
    wraps_d = wraps_q;
    if (CNT_CLR) begin
      wraps_d = '0;
    end else if (wrap_evt) begin
      wraps_d = wraps_q + 1'b1;
    end
  end

  // Captures always use the pre-update wrap count seen at this edge.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (CAP) begin
          snap_d  = {wraps_q, Q};
          state_d = FULL;
        end
      end
      FULL: begin
        if (RDY) begin
          if (CAP) begin
            snap_d = {wraps_q, Q};
          end else begin
            state_d = EMPTY;
          end
        end else if (CAP) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A drop on the same edge as CLR_OVF keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wraps_q <= '0;
      snap_q  <= '0;
      state_q <= EMPTY;
      ovf_q   <= 1'b0;
    end else begin
      wraps_q <= wraps_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign SNAP  = snap_q;
  assign VALID = (state_q == FULL);
  assign OVF   = ovf_q;
  assign WRAPS = wraps_q;

endmodule

// File: tb/tb_tc_capture.sv
// Directed bench for tc_capture: wrap counting, capture hand-off, backpressure and reset.
module tb_tc_capture;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  Q;
  logic        RCO, CNT_CLR, CAP, RDY, CLR_OVF;
  logic [11:0] SNAP;
  logic        VALID, OVF;
  logic [7:0]  WRAPS;

  int tests = 0;
  int fails = 0;

  tc_capture #(.WRAP_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Q       (Q),
    .RCO     (RCO),
    .CNT_CLR (CNT_CLR),
    .CAP     (CAP),
    .RDY     (RDY),
    .CLR_OVF (CLR_OVF),
    .SNAP    (SNAP),
    .VALID   (VALID),
    .OVF     (OVF),
    .WRAPS   (WRAPS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rco();
    RCO = 1'b1;
    tick();
    RCO = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1; Q = 4'h0; RCO = 1'b0; CNT_CLR = 1'b0;
    CAP = 1'b0; RDY = 1'b1; CLR_OVF = 1'b0;
    #1;
    check("reset_wraps", 32'(WRAPS), 32'h0);
    check("reset_valid", 32'(VALID), 32'h0);
    check("reset_ovf",   32'(OVF),   32'h0);
    check("reset_snap",  32'(SNAP),  32'h0);
    tick();
    RST = 1'b0;
    tick();

    // Three single-cycle pulses, then a 10-cycle high level counts once.
    for (int i = 0; i < 3; i++) pulse_rco();
    check("wraps_3_pulses", 32'(WRAPS), 32'd3);
    RCO = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    RCO = 1'b0;
    tick();
    check("wraps_held_high", 32'(WRAPS), 32'd4);

    // Capture without backpressure at WRAPS=5.
    pulse_rco();
    Q = 4'hA; CAP = 1'b1; RDY = 1'b1;
    tick();
    CAP = 1'b0;
    check("cap_snap",  32'(SNAP),  32'h05A);
    check("cap_valid", 32'(VALID), 32'h1);
    tick();
    check("cap_consumed", 32'(VALID), 32'h0);
    check("cap_snap_kept", 32'(SNAP), 32'h05A);
    tick();
    check("rdy_empty_noeffect", 32'(VALID), 32'h0);

    // Capture on the same edge as a wrap at WRAPS=7.
    pulse_rco();
    pulse_rco();
    Q = 4'hF; RCO = 1'b1; CAP = 1'b1;
    tick();
    RCO = 1'b0; CAP = 1'b0;
    check("wrapcap_snap",  32'(SNAP),  32'h07F);
    check("wrapcap_wraps", 32'(WRAPS), 32'd8);
    tick();
    check("wrapcap_consumed", 32'(VALID), 32'h0);

    // Backpressure: second capture is dropped and OVF set.
    RDY = 1'b0; Q = 4'h1; CAP = 1'b1;
    tick();
    check("bp_first_snap", 32'(SNAP), 32'h081);
    check("bp_first_ovf",  32'(OVF),  32'h0);
    Q = 4'h2;
    tick();
    CAP = 1'b0;
    check("bp_drop_snap",  32'(SNAP),  32'h081);
    check("bp_drop_ovf",   32'(OVF),   32'h1);
    check("bp_drop_valid", 32'(VALID), 32'h1);
    tick();
    check("bp_hold_snap",  32'(SNAP),  32'h081);
    check("bp_hold_valid", 32'(VALID), 32'h1);
    RDY = 1'b1;
    tick();
    check("bp_release_valid", 32'(VALID), 32'h0);
    check("bp_ovf_sticky",    32'(OVF),   32'h1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("ovf_cleared", 32'(OVF), 32'h0);

    // Drop coincident with CLR_OVF: set wins.
    RDY = 1'b0; Q = 4'h3; CAP = 1'b1;
    tick();
    Q = 4'h4; CLR_OVF = 1'b1;
    tick();
    CAP = 1'b0; CLR_OVF = 1'b0;
    check("ovf_set_wins", 32'(OVF),  32'h1);
    check("ovf_set_snap", 32'(SNAP), 32'h083);
    RDY = 1'b1;
    tick();
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("ovf_cleared2", 32'(OVF), 32'h0);

    // Clear beats a coincident wrap, then 256 pulses wrap back to 0.
    RCO = 1'b1; CNT_CLR = 1'b1;
    tick();
    RCO = 1'b0; CNT_CLR = 1'b0;
    check("clr_beats_wrap", 32'(WRAPS), 32'h0);
    tick();
    for (int i = 0; i < 255; i++) pulse_rco();
    check("wraps_255", 32'(WRAPS), 32'd255);
    pulse_rco();
    check("wraps_modulo", 32'(WRAPS), 32'h0);
    check("wraps_mod_ovf", 32'(OVF), 32'h0);

    // Back-to-back captures with WRAPS=1.
    pulse_rco();
    RDY = 1'b1; CAP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Q = 4'(i + 5);
      tick();
      check("b2b_valid", 32'(VALID), 32'h1);
      check("b2b_snap",  32'(SNAP),  32'h010 + 32'(i + 5));
    end

    // Asynchronous reset mid-cycle while FULL.
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_valid", 32'(VALID), 32'h0);
    check("async_rst_wraps", 32'(WRAPS), 32'h0);
    check("async_rst_snap",  32'(SNAP),  32'h0);
    check("async_rst_ovf",   32'(OVF),   32'h0);
    RCO = 1'b1;
    tick();
    check("cap_in_reset", 32'(VALID), 32'h0);
    CAP = 1'b0;
    RST = 1'b0;
    tick();
    check("rco_high_after_rst", 32'(WRAPS), 32'd1);
    tick();
    check("rco_high_once", 32'(WRAPS), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
